// File: rtl/lsu_pkg.sv
// Shared definitions for the load-store unit: access-size codes, FSM states
// and the alignment/legality rule used when an access is first presented.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      WAIT = 2'b10,
      DONE = 2'b11
   } lsuState_e;

   // Funct3[1:0] encodes the size for both loads and stores, so misalignment
   // only needs the size bits; the sign bit only matters for legality.
   function automatic logic accessFault(input logic       isStore,
                                        input logic [2:0] f3,
                                        input logic [1:0] lane);
      logic illegal;
      logic misaligned;
      if (isStore)
         illegal = (f3 > F3_W);
      else
         illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      misaligned = ((f3[1:0] == 2'b01) && lane[0]) ||
                   ((f3[1:0] == 2'b10) && (lane != 2'b00));
      return illegal | misaligned;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half/word out of a bus read word and sign- or
// zero-extends it to 32 bits for write-back.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  lane_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [7:0]  byteSel;
   logic [15:0] halfSel;

   always_comb begin
      byteSel = rdata_i[{lane_i, 3'b000} +: 8];
      halfSel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (funct3_i)
         F3_B:    data_o = {{24{byteSel[7]}}, byteSel};
         F3_BU:   data_o = {24'h0, byteSel};
         F3_H:    data_o = {{16{halfSel[15]}}, halfSel};
         F3_HU:   data_o = {16'h0, halfSel};
         F3_W:    data_o = rdata_i;
         default: data_o = 32'h0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load-store unit: one req/gnt/rvalid bus access per instruction,
// stalling the core until the access completes, faults or times out.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  Funct3,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        MisalignFault,
   output logic        BusFault,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   input  logic        mem_err
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

   lsuState_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       lane_q, lane_d;
   logic [2:0]       f3_q, f3_d;
   logic             store_q, store_d;
   logic             req_q, req_d;
   logic             we_q, we_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [3:0]       be_q, be_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             misalign_q, misalign_d;
   logic             busFault_q, busFault_d;
   logic [31:0]      loadData;
   logic [31:0]      storeData;
   logic [3:0]       accessBe;
   logic             timeout;

   lsu_load_align u_align (
      .rdata_i  (mem_rdata),
      .lane_i   (lane_q),
      .funct3_i (f3_q),
      .data_o   (loadData)
   );

   always_comb begin
      case (Funct3[1:0])
         2'b00:   begin
            storeData = {4{WriteData[7:0]}};
            accessBe  = 4'b0001 << ALUResult[1:0];
         end
         2'b01:   begin
            storeData = {2{WriteData[15:0]}};
            accessBe  = 4'b0011 << ALUResult[1:0];
         end
         default: begin
            storeData = WriteData;
            accessBe  = 4'b1111;
         end
      endcase
   end

   assign timeout = (cnt_q == LAST_CNT);

   // Bus fields default to zero and are only re-asserted while in REQ, so
   // mem_req drops on the cycle after a grant or a timeout.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      lane_d     = lane_q;
      f3_d       = f3_q;
      store_d    = store_q;
      req_d      = 1'b0;
      we_d       = 1'b0;
      addr_d     = 32'h0;
      wdata_d    = 32'h0;
      be_d       = 4'h0;
      rdata_d    = 32'h0;
      misalign_d = 1'b0;
      busFault_d = 1'b0;
      Stall      = 1'b0;
      case (state_q)
         IDLE: begin
            Stall = MemRead | MemWrite;
            if (MemRead | MemWrite) begin
               lane_d  = ALUResult[1:0];
               f3_d    = Funct3;
               store_d = MemWrite;
               cnt_d   = '0;
               if (accessFault(MemWrite, Funct3, ALUResult[1:0])) begin
                  state_d    = DONE;
                  misalign_d = 1'b1;
               end else begin
                  state_d = REQ;
                  req_d   = 1'b1;
                  we_d    = MemWrite;
                  addr_d  = {ALUResult[31:2], 2'b00};
                  wdata_d = MemWrite ? storeData : 32'h0;
                  be_d    = accessBe;
               end
            end
         end
         REQ, WAIT: begin
            Stall = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (mem_rvalid && (state_q == WAIT || mem_gnt)) begin
               state_d    = DONE;
               busFault_d = mem_err;
               rdata_d    = (mem_err || store_q) ? 32'h0 : loadData;
            end else if (timeout) begin
               state_d    = DONE;
               busFault_d = 1'b1;
            end else if (state_q == REQ && mem_gnt) begin
               state_d = WAIT;
            end else if (state_q == REQ) begin
               req_d   = 1'b1;
               we_d    = we_q;
               addr_d  = addr_q;
               wdata_d = wdata_q;
               be_d    = be_q;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         lane_q     <= 2'b00;
         f3_q       <= 3'b000;
         store_q    <= 1'b0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         be_q       <= 4'h0;
         rdata_q    <= 32'h0;
         misalign_q <= 1'b0;
         busFault_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         lane_q     <= lane_d;
         f3_q       <= f3_d;
         store_q    <= store_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         rdata_q    <= rdata_d;
         misalign_q <= misalign_d;
         busFault_q <= busFault_d;
      end
   end

   assign ReadData      = rdata_q;
   assign MisalignFault = misalign_q;
   assign BusFault      = busFault_q;
   assign mem_req       = req_q;
   assign mem_we        = we_q;
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;
   assign mem_be        = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised and directed bench for load_store_unit; expected outputs come from
// a per-access timeline model driven by the bench's own bus responder.
module tb_load_store_unit;

   localparam int T = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        MemRead, MemWrite;
   logic [2:0]  Funct3;
   logic [31:0] ALUResult, WriteData, ReadData;
   logic        Stall, MisalignFault, BusFault;
   logic        mem_req, mem_we, mem_gnt, mem_rvalid, mem_err;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
      .Funct3(Funct3), .ALUResult(ALUResult), .WriteData(WriteData),
      .ReadData(ReadData), .Stall(Stall), .MisalignFault(MisalignFault),
      .BusFault(BusFault), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   logic        checkEn = 1'b0;
   logic        expStall, expReq, expMis, expBusF, expDone, expWe, expStore;
   logic [31:0] expRd, expAddr, expWdata;
   logic [3:0]  expBe;
   logic [31:0] lastRd;
   logic        lastMis, lastBusF;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Access is legal when the code exists for its direction and the address
   // is a multiple of the access size.
   function automatic logic modelFault(input logic isStore, input logic [2:0] f3, input logic [31:0] addr);
      int sz;
      if (isStore && f3 > 3'd2) return 1'b1;
      if (!isStore && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
      sz = 1 << f3[1:0];
      return (int'(addr[1:0]) % sz) != 0;
   endfunction

   function automatic logic [31:0] modelLoad(input logic [31:0] word, input logic [1:0] a, input logic [2:0] f3);
      logic [31:0] v;
      if (f3[1:0] == 2'd2) return word;
      if (f3[1:0] == 2'd0) begin
         v = (word >> (8 * int'(a))) & 32'hFF;
         if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
      end else begin
         v = (word >> (8 * int'(a))) & 32'hFFFF;
         if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
      end
      return v;
   endfunction

   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("Stall", 32'(Stall), 32'(expStall));
         checkOutput("mem_req", 32'(mem_req), 32'(expReq));
         checkOutput("MisalignFault", 32'(MisalignFault), 32'(expMis));
         checkOutput("BusFault", 32'(BusFault), 32'(expBusF));
         checkOutput("ReadData", ReadData, expRd);
         if (expReq) begin
            checkOutput("mem_we", 32'(mem_we), 32'(expWe));
            checkOutput("mem_addr", mem_addr, expAddr);
            checkOutput("mem_be", 32'(mem_be), 32'(expBe));
            if (expStore) checkOutput("mem_wdata", mem_wdata, expWdata);
         end
         if (expDone) begin
            lastRd   = ReadData;
            lastMis  = MisalignFault;
            lastBusF = BusFault;
         end
      end
   end

   // One access: bus grants g cycles into REQ and responds r cycles after
   // the grant; the whole cycle-by-cycle expectation follows from that.
   task automatic applyStimulus(input logic isStore, input logic alsoRead, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input int g, input int r, input logic err, input logic [31:0] rdata);
      logic fault, accepted;
      int   n, doneC, sz;
      fault    = modelFault(isStore, f3, addr);
      accepted = !fault && (g + r < T);
      n        = fault ? 0 : (accepted ? g + r + 1 : T);
      doneC    = n + 1;
      sz       = 1 << f3[1:0];
      for (int c = 0; c <= doneC; c++) begin
         @(posedge clk); #1;
         MemRead    = !isStore || alsoRead;
         MemWrite   = isStore;
         Funct3     = f3;
         ALUResult  = addr;
         WriteData  = wd;
         mem_gnt    = !fault && (c == 1 + g);
         mem_rvalid = !fault && (c == 1 + g + r);
         mem_rdata  = (c == 1 + g + r) ? rdata : $urandom;
         mem_err    = (c == 1 + g + r) ? err : 1'($urandom_range(0, 1));
         expDone    = (c == doneC);
         expStall   = !expDone;
         expReq     = !fault && c >= 1 && c <= n && (c - 1 <= g);
         expMis     = expDone && fault;
         expBusF    = expDone && !fault && (!accepted || err);
         expRd      = (expDone && accepted && !isStore && !err) ? modelLoad(rdata, addr[1:0], f3) : 32'h0;
         expWe      = isStore;
         expStore   = isStore;
         expAddr    = addr & 32'hFFFF_FFFC;
         expBe      = 4'(((1 << sz) - 1) << int'(addr[1:0]));
         expWdata   = (sz == 1) ? wd[7:0] * 32'h0101_0101 :
                      (sz == 2) ? wd[15:0] * 32'h0001_0001 : wd;
         checkEn    = 1'b1;
      end
      @(negedge clk); #1;
   endtask

   task automatic idleCycles(input int k, input logic stray, input logic [31:0] strayData);
      for (int c = 0; c < k; c++) begin
         @(posedge clk); #1;
         MemRead    = 1'b0;
         MemWrite   = 1'b0;
         mem_gnt    = stray;
         mem_rvalid = stray;
         mem_rdata  = strayData;
         mem_err    = 1'b0;
         expStall   = 1'b0; expReq = 1'b0; expMis = 1'b0; expBusF = 1'b0;
         expDone    = 1'b0; expRd = 32'h0; expStore = 1'b0;
         checkEn    = 1'b1;
      end
   endtask

   // Abandon an LW in REQ (stopCycle 1) or WAIT (stopCycle 2) with an async reset.
   task automatic resetMidAccess(input int stopCycle);
      checkEn = 1'b0;
      for (int c = 0; c <= stopCycle; c++) begin
         @(posedge clk); #1;
         MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h200;
         mem_gnt = (c == 1) && (stopCycle == 2); mem_rvalid = 1'b0; mem_err = 1'b0;
      end
      #1;
      if (stopCycle == 1) checkOutput("req_before_rst", 32'(mem_req), 32'd1);
      MemRead = 1'b0; mem_gnt = 1'b0;
      rst = 1'b1;
      #1;
      checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
      checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
      checkOutput("rst_mem_addr", mem_addr, 32'h0);
      checkOutput("rst_mem_be", 32'(mem_be), 32'd0);
      checkOutput("rst_Stall", 32'(Stall), 32'd0);
      checkOutput("rst_faults", {30'h0, MisalignFault, BusFault}, 32'h0);
      checkOutput("rst_ReadData", ReadData, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      idleCycles(2, 1'b1, 32'h0000_5555);
      applyStimulus(1'b0, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 0, 1, 1'b0, 32'h1357_9BDF);
      checkOutput("after_rst_lw", lastRd, 32'h1357_9BDF);
   endtask

   initial begin
      rst = 1'b1;
      MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000; ALUResult = 32'h0; WriteData = 32'h0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_err = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
      checkOutput("reset_ReadData", ReadData, 32'h0);
      checkOutput("reset_Stall", 32'(Stall), 32'd0);
      checkOutput("reset_faults", {30'h0, MisalignFault, BusFault}, 32'h0);
      rst = 1'b0;

      checkOutput("model_lb", modelLoad(32'h80FF_0000, 2'd3, 3'b000), 32'hFFFF_FF80);
      checkOutput("model_lbu", modelLoad(32'h80FF_0000, 2'd3, 3'b100), 32'h0000_0080);
      checkOutput("model_lhu", modelLoad(32'h80FF_0000, 2'd2, 3'b101), 32'h0000_80FF);
      checkOutput("model_lw_mis", 32'(modelFault(1'b0, 3'b010, 32'h102)), 32'd1);

      applyStimulus(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 0, 1, 1'b0, 32'hDEAD_BEEF);
      checkOutput("lw_rd", lastRd, 32'hDEAD_BEEF);
      applyStimulus(1'b0, 1'b0, 3'b000, 32'h103, 32'h0, 0, 1, 1'b0, 32'h80FF_0000);
      checkOutput("lb_rd", lastRd, 32'hFFFF_FF80);
      applyStimulus(1'b0, 1'b0, 3'b100, 32'h103, 32'h0, 1, 0, 1'b0, 32'h80FF_0000);
      checkOutput("lbu_rd", lastRd, 32'h0000_0080);
      applyStimulus(1'b0, 1'b0, 3'b101, 32'h102, 32'h0, 0, 2, 1'b0, 32'h80FF_0000);
      checkOutput("lhu_rd", lastRd, 32'h0000_80FF);
      applyStimulus(1'b1, 1'b0, 3'b000, 32'h101, 32'h1234_56AB, 3, 1, 1'b0, 32'h0);
      checkOutput("sb_rd", lastRd, 32'h0);
      applyStimulus(1'b0, 1'b0, 3'b010, 32'h102, 32'h0, 0, 1, 1'b0, 32'h0);
      checkOutput("lw_misalign", 32'(lastMis), 32'd1);
      applyStimulus(1'b0, 1'b0, 3'b010, 32'h104, 32'h0, 0, 40, 1'b0, 32'h0);
      checkOutput("timeout_busfault", 32'(lastBusF), 32'd1);
      checkOutput("timeout_rd", lastRd, 32'h0);
      idleCycles(3, 1'b1, 32'h0000_5555);
      applyStimulus(1'b0, 1'b0, 3'b010, 32'h108, 32'h0, 0, 1, 1'b0, 32'hCAFE_F00D);
      checkOutput("post_timeout_lw", lastRd, 32'hCAFE_F00D);
      applyStimulus(1'b0, 1'b0, 3'b010, 32'h10C, 32'h0, 0, 0, 1'b1, 32'h1111_1111);
      checkOutput("gnt_rvalid_err", 32'(lastBusF), 32'd1);

      resetMidAccess(2);
      resetMidAccess(1);

      for (int i = 0; i < 250; i++) begin
         logic        isSt;
         int          g, r;
         isSt = 1'($urandom_range(0, 1));
         g = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 3);
         r = ($urandom_range(0, 9) == 0) ? $urandom_range(12, 20) : $urandom_range(0, 3);
         applyStimulus(isSt, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                       $urandom, g, r, $urandom_range(0, 7) == 0, $urandom);
         if ($urandom_range(0, 2) == 0)
            idleCycles($urandom_range(1, 2), 1'($urandom_range(0, 1)), $urandom);
      end

      idleCycles(2, 1'b0, 32'h0);
      @(posedge clk); #1;
      checkEn = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
